// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores over a req/ack data port and stalls the pipeline until done.
// Optional misalignment detection is enabled with `define MEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
    input  logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_reg_wdata,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [DATA_W-1:0]     mem_rt_data,
    output logic [REG_ADDR_W-1:0] wb_reg_waddr,
    output logic                  wb_we,
    output logic [DATA_W-1:0]     wb_reg_wdata,
    output logic                  stallreq,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [ADDR_W-1:0]     dm_addr,
    output logic [3:0]            dm_be,
    output logic [DATA_W-1:0]     dm_wdata,
    input  logic                  dm_ack,
    input  logic [DATA_W-1:0]     dm_rdata,
    output logic                  excp_misaligned,
    output logic                  excp_bus_err
);

    localparam logic [ALUOP_W-1:0] OP_LB  = ALUOP_W'(8'h20);
    localparam logic [ALUOP_W-1:0] OP_LH  = ALUOP_W'(8'h21);
    localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'h22);
    localparam logic [ALUOP_W-1:0] OP_LBU = ALUOP_W'(8'h23);
    localparam logic [ALUOP_W-1:0] OP_LHU = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] OP_SB  = ALUOP_W'(8'h28);
    localparam logic [ALUOP_W-1:0] OP_SH  = ALUOP_W'(8'h29);
    localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'h2A);
    localparam logic [15:0]        TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t             state, state_nxt;
    logic [15:0]        wait_cnt;
    logic [DATA_W-1:0]  rdata_q;

    logic               is_load, is_store, is_mem, is_uns, misalign, start, timeout_hit;
    size_t              size;
    logic [1:0]         lane;
    logic [3:0]         be_nxt;
    logic [31:0]        wdata_nxt;
    logic [DATA_W-1:0]  load_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Opcode decode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_uns   = 1'b0;
        size     = SZ_W;
        case (mem_aluop)
            OP_LB:  begin is_load  = 1'b1; size = SZ_B; end
            OP_LH:  begin is_load  = 1'b1; size = SZ_H; end
            OP_LW:  begin is_load  = 1'b1; size = SZ_W; end
            OP_LBU: begin is_load  = 1'b1; size = SZ_B; is_uns = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = SZ_H; is_uns = 1'b1; end
            OP_SB:  begin is_store = 1'b1; size = SZ_B; end
            OP_SH:  begin is_store = 1'b1; size = SZ_H; end
            OP_SW:  begin is_store = 1'b1; size = SZ_W; end
            default: ;
        endcase
    end

    assign is_mem = is_load | is_store;
    assign lane   = mem_mem_addr[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = is_mem && (((size == SZ_H) && lane[0]) ||
                                 ((size == SZ_W) && (lane != 2'b00)));
    assign excp_misaligned = (state == IDLE) && misalign;
`else
    assign misalign        = 1'b0;
    assign excp_misaligned = 1'b0;
`endif

    assign start       = (state == IDLE) && is_mem && !misalign;
    assign timeout_hit = (wait_cnt == TO_LAST);

    // Lane enables and replicated store data; halves only look at addr[1]
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = 32'(mem_rt_data);
        case (size)
            SZ_B: begin
                be_nxt    = 4'b0001 << lane;
                wdata_nxt = {4{mem_rt_data[7:0]}};
            end
            SZ_H: begin
                be_nxt    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{mem_rt_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stallreq  = 1'b0;
        case (state)
            IDLE: if (start) begin
                stallreq  = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                stallreq = 1'b1;
                if (dm_ack || timeout_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_be        <= 4'b0000;
            dm_wdata     <= '0;
            rdata_q      <= '0;
            wait_cnt     <= '0;
            excp_bus_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            excp_bus_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    dm_req   <= 1'b1;
                    dm_we    <= is_store;
                    dm_addr  <= {mem_mem_addr[ADDR_W-1:2], 2'b00};
                    dm_be    <= be_nxt;
                    dm_wdata <= DATA_W'(wdata_nxt);
                    wait_cnt <= '0;
                end
                REQ: begin
                    // An ack in the last allowed cycle still wins over the timeout
                    if (dm_ack) begin
                        rdata_q <= dm_rdata;
                        dm_req  <= 1'b0;
                    end else if (timeout_hit) begin
                        dm_req       <= 1'b0;
                        excp_bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction from the captured word
    always_comb begin
        case (lane)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size)
            SZ_B:    load_data = {{(DATA_W-8){ld_byte[7] & ~is_uns}}, ld_byte};
            SZ_H:    load_data = {{(DATA_W-16){ld_half[15] & ~is_uns}}, ld_half};
            default: load_data = rdata_q;
        endcase
    end

    // excp_bus_err is high exactly in the DONE cycle following a timeout
    always_comb begin
        wb_reg_waddr = mem_reg_waddr;
        wb_reg_wdata = mem_reg_wdata;
        wb_we        = mem_we;
        if (is_mem) begin
            wb_we = 1'b0;
            if ((state == DONE) && is_load && !excp_bus_err) begin
                wb_we        = mem_we;
                wb_reg_wdata = load_data;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits between the EX/MEM and MEM/WB pipeline registers and consumes the EX/MEM register outputs: destination register, write enable, ALU result, memory address, ALU opcode and store data. Loads and stores run over a req/ack data-memory port through a small FSM. The block raises `stallreq` to hold the front of the pipeline until the access completes, then presents write-back data to MEM/WB.

## Interface
- `DATA_W`, 32, register/data width
- `ADDR_W`, 32, data-memory address width
- `REG_ADDR_W`, 5, register-file address width
- `ALUOP_W`, 8, ALU opcode width
- `TIMEOUT`, 255, maximum cycles to wait for `dm_ack` (1..65535)
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — synchronous, active-high reset
- `mem_reg_waddr` in REG_ADDR_W — destination register from EX/MEM
- `mem_we` in 1 — register write enable from EX/MEM
- `mem_reg_wdata` in DATA_W — ALU result from EX/MEM
- `mem_mem_addr` in ADDR_W — effective address
- `mem_aluop` in ALUOP_W — opcode
- `mem_rt_data` in DATA_W — store data (rs2)
- `wb_reg_waddr` out REG_ADDR_W — to MEM/WB
- `wb_we` out 1 — to MEM/WB
- `wb_reg_wdata` out DATA_W — to MEM/WB
- `stallreq` out 1 — pipeline stall request to stall controller
- `dm_req` out 1 — memory request, registered
- `dm_we` out 1 — 1 = store, registered
- `dm_addr` out ADDR_W — word-aligned (`addr[1:0]=0`), registered
- `dm_be` out 4 — byte enables, registered
- `dm_wdata` out DATA_W — lane-replicated store data, registered
- `dm_ack` in 1 — access complete; read data valid in the same cycle
- `dm_rdata` in DATA_W — read word
- `excp_misaligned` out 1 — one-cycle pulse on a misaligned access
- `excp_bus_err` out 1 — one-cycle pulse on timeout

## Operation
- Opcodes: LB=8'h20, LH=8'h21, LW=8'h22, LBU=8'h23, LHU=8'h24, SB=8'h28, SH=8'h29, SW=8'h2A. All other opcodes are non-memory.
- Non-memory op: `wb_*` = `mem_*` combinationally. No stall, no request.
- FSM states: IDLE, REQ, DONE.
- IDLE + memory op (aligned):
  - `stallreq`=1 combinationally.
  - Next state REQ.
  - At the same edge, load `dm_addr`, `dm_we`, `dm_be`, `dm_wdata`, and set `dm_req`=1.
- REQ:
  - `stallreq`=1; `dm_req` and all `dm_*` outputs held stable.
  - On `dm_ack`=1: latch `dm_rdata` into `rdata_q`, clear `dm_req`, go to DONE.
  - Wait counter increments each REQ cycle. When the count reaches TIMEOUT without an ack: pulse `excp_bus_err`, clear `dm_req`, go to DONE with `wb_we` forced to 0.
- DONE:
  - `stallreq`=0; `wb_*` valid; return to IDLE at the next edge.
  - Loads: `wb_we`=`mem_we` and `wb_reg_wdata` = extracted lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the full word.
  - Stores: `wb_we`=0.
- Byte lanes are selected by `addr[1:0]`.
  - Byte: `dm_be` = 1<<addr[1:0].
  - Half: `dm_be` = 4'b0011 or 4'b1100.
  - Word: `dm_be` = 4'b1111.
  - `dm_wdata`: byte replicated ×4, half replicated ×2.
- Misalignment:
  - Condition: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - Response: no request, no stall, `wb_we`=0, `excp_misaligned` pulsed for the IDLE cycle.
- `dm_ack` outside REQ is ignored.

## Timing
- Reset values: state=IDLE, `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_be`=0, `dm_wdata`=0, `rdata_q`=0, counter=0, `excp_*`=0. `stallreq` and `wb_*` follow their combinational rules with state=IDLE.
- Minimum memory-op occupancy is 3 cycles:
  - C0: IDLE, stall.
  - C1: REQ, ack.
  - C2: DONE, write-back, no stall.
  - C3: next instruction.
- Each cycle of ack delay adds one REQ cycle.
- Reset asserted in any state: the next edge forces IDLE and `dm_req`=0. An in-flight access is abandoned and no write-back or exception is issued.
- Back-to-back memory ops: DONE always returns to IDLE, so the next op starts its own C0.
- Timeout: `excp_bus_err` is high in the first DONE cycle only.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: misalignment detection and `excp_misaligned` as described.
- Not defined:
  - `excp_misaligned` is tied to 0.
  - Low address bits that violate alignment are ignored: half uses `addr[1]` only, word uses lanes 1111.
  - The access proceeds normally.

## Test plan
- ALU op `8'h01`, waddr=5, wdata=32'h1234 → `wb_*` mirror inputs in the same cycle; `stallreq`=0; `dm_req` never asserted.
- LB at addr 0x103, `dm_rdata`=32'h80FF_FF00, ack in first REQ cycle → `dm_be`=4'b1000, `dm_addr`=0x100. DONE `wb_reg_wdata`=32'hFFFF_FF80, `wb_we`=1. `stallreq` is high for exactly 2 cycles.
- SH at 0x202, rt_data=32'hAAAA_BEEF, ack after 4 REQ cycles → `dm_we`=1, `dm_be`=4'b1100, `dm_wdata`=32'hBEEF_BEEF. `wb_we`=0. `stallreq` is high for 5 cycles.
- LW at 0x301 with `MEM_MISALIGN_CHECK_EN` → `excp_misaligned` 1-cycle pulse, no `dm_req`, `wb_we`=0, no stall.
- TIMEOUT=8, LHU with no ack → `dm_req` high for 8 cycles, then `excp_bus_err` pulse, `wb_we`=0, FSM back in IDLE.
- LW in REQ, `rst`=1 for one cycle → `dm_req`=0 and state IDLE after that edge; a later ack is ignored; no `excp_*` pulse.
